// File: rtl/prod_pkg.sv
// Shared types and cycle budgets for the program-3 product engine.
package prod_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      MUL,
      WRITE,
      FIN
   } state_t;

   localparam int CYC_READ     = 5;
   localparam int CYC_MUL      = 16;
   localparam int CYC_WRITE    = 4;
   localparam int CYC_PER_PAIR = CYC_READ + CYC_MUL + CYC_WRITE;

endpackage

// File: rtl/shift_add_mul16.sv
// Sequential 16x16 unsigned shift-add multiplier; one multiplier bit (LSB first) per cycle.
module shift_add_mul16
   import prod_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Load,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [31:0] Prod,
   output logic        Busy
);

   logic [31:0] mcand;
   logic [15:0] mplier;
   logic [4:0]  cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         Prod   <= '0;
      end else if (Load) begin
         mcand  <= {16'd0, A};
         mplier <= B;
         cnt    <= 5'(CYC_MUL);
         Prod   <= '0;
      end else if (cnt != 5'd0) begin
         if (mplier[0])
            Prod <= Prod + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 5'd1;
      end
   end

   assign Busy = (cnt != 5'd0);

endmodule

// File: rtl/prod_mem_engine.sv
// Reads NUM_PAIRS big-endian 16-bit operand pairs, multiplies each, writes 32-bit products back.
module prod_mem_engine
   import prod_pkg::*;
#(
   parameter int BASE_IN   = 0,
   parameter int BASE_OUT  = 64,
   parameter int NUM_PAIRS = 16,
   parameter int MEM_AW    = 8
)
(
   input  logic              Clk,
   input  logic              Reset,
   output logic              Done,
   output logic [MEM_AW-1:0] MemAddr,
   input  logic [7:0]        MemRdData,
   output logic [7:0]        MemWrData,
   output logic              MemWrEn
);

   localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

   state_t            state, state_next;
   logic [4:0]        cyc, cyc_next;
   logic [PW-1:0]     pair, pair_next;
   logic [7:0]        a_hi, a_lo, b_hi;
   logic              mul_load, mul_busy;
   logic [31:0]       prod;
   logic [MEM_AW-1:0] pair_base;

   assign pair_base = MEM_AW'({pair, 2'b00});

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cyc   <= '0;
         pair  <= '0;
         a_hi  <= '0;
         a_lo  <= '0;
         b_hi  <= '0;
         Done  <= 1'b0;
      end else begin
         state <= state_next;
         cyc   <= cyc_next;
         pair  <= pair_next;
         Done  <= (state == FIN);
         // Registered memory: the byte addressed in cycle k arrives in cycle k+1.
         if (state == READ) begin
            case (cyc)
               5'd1:    a_hi <= MemRdData;
               5'd2:    a_lo <= MemRdData;
               5'd3:    b_hi <= MemRdData;
               default: ;
            endcase
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      cyc_next   = cyc + 5'd1;
      pair_next  = pair;
      mul_load   = 1'b0;
      MemAddr    = '0;
      MemWrData  = '0;
      MemWrEn    = 1'b0;
      unique case (state)
         IDLE: begin
            state_next = READ;
            cyc_next   = '0;
         end
         READ: begin
            MemAddr = MEM_AW'(BASE_IN) + pair_base + MEM_AW'(cyc);
            if (cyc == 5'(CYC_READ - 1)) begin
               mul_load   = 1'b1;
               state_next = MUL;
               cyc_next   = '0;
            end
         end
         MUL: begin
            if (cyc == 5'(CYC_MUL - 1)) begin
               state_next = WRITE;
               cyc_next   = '0;
            end
         end
         WRITE: begin
            MemAddr = MEM_AW'(BASE_OUT) + pair_base + MEM_AW'(cyc);
            MemWrEn = ~mul_busy;
            case (cyc[1:0])
               2'd0:    MemWrData = prod[31:24];
               2'd1:    MemWrData = prod[23:16];
               2'd2:    MemWrData = prod[15:8];
               default: MemWrData = prod[7:0];
            endcase
            if (cyc == 5'(CYC_WRITE - 1)) begin
               cyc_next = '0;
               if (pair == PW'(NUM_PAIRS - 1)) begin
                  state_next = FIN;
               end else begin
                  pair_next  = pair + PW'(1);
                  state_next = READ;
               end
            end
         end
         FIN: begin
            cyc_next = cyc;
         end
         default: begin
            state_next = IDLE;
            cyc_next   = '0;
         end
      endcase
   end

   // The final operand byte feeds the multiplier straight from the read port.
   shift_add_mul16 u_mul (
      .Clk   (Clk),
      .Reset (Reset),
      .Load  (mul_load),
      .A     ({a_hi, a_lo}),
      .B     ({b_hi, MemRdData}),
      .Prod  (prod),
      .Busy  (mul_busy)
   );

endmodule

// File: tb/tb_prod_mem_engine.sv
// Directed and random runs of prod_mem_engine against a byte-array memory and arithmetic golden model.
module tb_prod_mem_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] rd_data;
   logic [7:0] wr_data;
   logic       wen;

   logic [7:0] mem  [256];
   logic [7:0] img  [256];
   logic [7:0] gold [256];
   logic       load_img;

   int vectors    = 0;
   int miscompares = 0;
   int wr_count   = 0;

   always #5 clk = ~clk;

   prod_mem_engine dut (
      .Clk       (clk),
      .Reset     (reset),
      .Done      (done),
      .MemAddr   (mem_addr),
      .MemRdData (rd_data),
      .MemWrData (wr_data),
      .MemWrEn   (wen)
   );

   always @(posedge clk) begin
      if (load_img) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else if (wen) begin
         mem[mem_addr] <= wr_data;
      end
      rd_data <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wen === 1'b1) begin
         wr_count++;
         check("wr_addr_floor", {31'd0, (mem_addr >= 8'd64)}, 32'd1);
      end
   end

   // Golden memory: inputs untouched, each product A*B stored big-endian at 64+4j.
   task automatic build_gold();
      logic [31:0] a, b, p;
      for (int i = 0; i < 256; i++) gold[i] = img[i];
      for (int j = 0; j < 16; j++) begin
         a = {16'd0, img[4*j], img[4*j+1]};
         b = {16'd0, img[4*j+2], img[4*j+3]};
         p = a * b;
         gold[64+4*j]   = p[31:24];
         gold[64+4*j+1] = p[23:16];
         gold[64+4*j+2] = p[15:8];
         gold[64+4*j+3] = p[7:0];
      end
   endtask

   function automatic logic [31:0] mem_word(input int addr);
      return {mem[addr], mem[addr+1], mem[addr+2], mem[addr+3]};
   endfunction

   task automatic run_image(input string tag, input int interrupt_at);
      int first;
      int bad;
      reset = 1'b1;
      @(negedge clk);
      load_img = 1'b1;
      @(negedge clk);
      load_img = 1'b0;
      check({tag, ":rst_done"}, {31'd0, done}, 32'd0);
      check({tag, ":rst_wen"}, {31'd0, wen}, 32'd0);
      check({tag, ":rst_addr"}, {24'd0, mem_addr}, 32'd0);
      check({tag, ":rst_wdata"}, {24'd0, wr_data}, 32'd0);
      reset = 1'b0;
      if (interrupt_at >= 0) begin
         repeat (interrupt_at) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         check({tag, ":mid_rst_done"}, {31'd0, done}, 32'd0);
         reset = 1'b0;
      end
      wr_count = 0;
      first = -1;
      for (int n = 0; n < 600 && first < 0; n++) begin
         @(negedge clk);
         if (done === 1'b1) first = n;
      end
      check({tag, ":done_cycle"}, 32'(first), 32'd401);
      check({tag, ":write_count"}, 32'(wr_count), 32'd64);
      build_gold();
      for (int j = 0; j < 16; j++)
         check($sformatf("%s:prod%0d", tag, j), mem_word(64 + 4*j),
               {gold[64+4*j], gold[64+4*j+1], gold[64+4*j+2], gold[64+4*j+3]});
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) bad++;
      check({tag, ":mem_image"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int bad;
      reset    = 1'b1;
      load_img = 1'b0;
      repeat (2) @(negedge clk);

      // Alternating 0x0001 / 0x0002 operands: every product is 2.
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      for (int j = 0; j < 16; j++) begin
         img[4*j+1] = 8'h01;
         img[4*j+3] = 8'h02;
      end
      run_image("alt12", -1);
      for (int j = 0; j < 16; j++)
         check($sformatf("alt12:const%0d", j), mem_word(64 + 4*j), 32'h0000_0002);

      // Largest operands in pair 0, zeros elsewhere.
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      for (int i = 0; i < 4; i++) img[i] = 8'hFF;
      run_image("ffff", -1);
      check("ffff:const", mem_word(64), 32'hFFFE_0001);
      check("ffff:zero1", mem_word(68), 32'h0000_0000);

      // Byte order: 0x1234 * 0x0010.
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
      img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h00; img[3] = 8'h10;
      run_image("order", -1);
      check("order:const", mem_word(64), 32'h0001_2340);

      // One-cycle reset pulse mid-run restarts from pair 0.
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
      run_image("midrst", 150);

      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
         run_image($sformatf("rand%0d", t), -1);
      end

      // Done must hold and writes stay off while idling in FIN.
      bad = 0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (done !== 1'b1 || wen !== 1'b0) bad++;
      end
      check("fin_hold", 32'(bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
